// File: rtl/eth_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_fifo
//
// Store-and-forward AXI-Stream frame FIFO between the MAC receive stream and
// eth_rx_gen. MAC words are accepted every cycle that s_axis_tvalid is high,
// because there is no backpressure on the MAC side. A frame becomes visible
// to the read side only after its tlast word arrives with tuser = 0. A frame
// is discarded whole, with a one-cycle rx_drop pulse, when either of these
// happens:
//   - tuser is set on its tlast word (bad FCS or PHY error)
//   - it runs out of buffer space.
//
// Parameters
//   AXIS_DATA_WIDTH  data width in bits; tkeep is AXIS_DATA_WIDTH/8 bits
//   ADDR_WIDTH       RAM address bits; the buffer holds 2**ADDR_WIDTH words
//
// Ports
//   clk, rstn        clock; asynchronous active-low reset
//   s_axis_*         MAC RX stream (tdata, tkeep, tvalid, tlast, tuser)
//   m_axis_*         frame stream to eth_rx_gen (tdata, tkeep, tvalid,
//                    tlast, tuser tied low, tready input)
//   rx_drop          one-cycle pulse whenever a frame is discarded
//
// Optional build macro
//   ETH_RX_FIFO_STATS_EN  adds the saturating 32-bit counters stat_ok_cnt,
//                         stat_err_cnt and stat_ovf_cnt
// ---------------------------------------------------------------------------
module eth_rx_frame_fifo #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 9
) (
    input  logic                         clk,
    input  logic                         rstn,

    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    input  logic                         m_axis_tready,

    output logic                         rx_drop
`ifdef ETH_RX_FIFO_STATS_EN
    ,
    output logic [31:0]                  stat_ok_cnt,
    output logic [31:0]                  stat_err_cnt,
    output logic [31:0]                  stat_ovf_cnt
`endif
);

    localparam int KW    = AXIS_DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int RW    = 1 + KW + AXIS_DATA_WIDTH;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_t;

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     wr_commit;
    logic [PW-1:0]     wr_commit_nxt;
    logic [PW-1:0]     rd_ptr;
    logic              ram_we;
    logic              drop_nxt;
    logic              full;
    logic              empty;

    logic [RW-1:0]     mem [DEPTH];
    logic [RW-1:0]     rd_data;
    logic              rd_en;
    logic              ram_vld;

    logic [1:0]        out_cnt;
    logic [RW-1:0]     head_q;
    logic [RW-1:0]     skid_q;
    logic              pop;
    logic [2:0]        stage_fill;

    // Pointers carry one extra wrap bit. A difference of exactly DEPTH
    // therefore means the RAM is full, and it is never confused with empty.
    // full is checked against the registered read pointer only. A read in
    // the same cycle does not rescue a word that meets a full buffer.
    assign full  = ((wr_ptr - rd_ptr) == PTR_DEPTH);
    assign empty = (rd_ptr == wr_commit);

    // Write-side registers: FSM state, speculative write pointer, commit
    // pointer and the registered drop pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rx_drop   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            rx_drop   <= drop_nxt;
        end
    end

    // Write-side next state.
    // Words are written speculatively at wr_ptr. A good tlast moves
    // wr_commit past the frame, so the read side sees the whole frame at
    // once. A bad tlast, or a word that finds the buffer full, rewinds
    // wr_ptr to wr_commit. That rewind throws away every partial word of
    // the frame. A full buffer also sends the FSM to ST_DROP, which ignores
    // words up to the frame's tlast.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        ram_we        = 1'b0;
        drop_nxt      = 1'b0;
        case (state)
            ST_IDLE, ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (!full) begin
                        ram_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                        state_nxt  = ST_WRITE;
                        if (s_axis_tlast) begin
                            state_nxt = ST_IDLE;
                            if (s_axis_tuser) begin
                                wr_ptr_nxt = wr_commit;
                                drop_nxt   = 1'b1;
                            end else begin
                                wr_commit_nxt = wr_ptr + PTR_ONE;
                            end
                        end
                    end else begin
                        wr_ptr_nxt = wr_commit;
                        if (s_axis_tlast) begin
                            drop_nxt  = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame RAM with a registered read port. Its contents are not reset.
    // After a reset the pointers are equal, so old data is never read.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (rd_en) begin
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    // Read issue control.
    // stage_fill is the number of output-stage slots that will be taken
    // once the word now in flight from the RAM has landed. The count
    // accounts for this cycle's pop. A new read issues only if that word is
    // sure to find a slot. With tready high, the result is one read per
    // clock.
    assign pop        = (out_cnt != 2'd0) && m_axis_tready;
    assign stage_fill = {1'b0, out_cnt} + {2'b00, ram_vld} - {2'b00, pop};
    assign rd_en      = !empty && (stage_fill < 3'd2);

    // Read pointer, RAM-data valid flag, and the two-entry output stage.
    // head_q drives the m_axis outputs. skid_q holds the word that arrives
    // while the head is stalled, so the head stays stable until it is
    // accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr  <= '0;
            ram_vld <= 1'b0;
            out_cnt <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            ram_vld <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (out_cnt)
                2'd0: begin
                    if (ram_vld) begin
                        head_q  <= rd_data;
                        out_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (ram_vld && pop) begin
                        head_q <= rd_data;
                    end else if (ram_vld) begin
                        skid_q  <= rd_data;
                        out_cnt <= 2'd2;
                    end else if (pop) begin
                        out_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (ram_vld) begin
                            skid_q <= rd_data;
                        end else begin
                            out_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign m_axis_tvalid = (out_cnt != 2'd0);
    assign m_axis_tdata  = head_q[AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = head_q[AXIS_DATA_WIDTH +: KW];
    assign m_axis_tlast  = head_q[RW-1];
    assign m_axis_tuser  = 1'b0;

`ifdef ETH_RX_FIFO_STATS_EN
    logic ok_inc;
    logic err_inc;
    logic ovf_inc;

    // wr_commit moves only when a good frame is committed. A drop counts as
    // an error drop when its tlast was written with tuser set. Every other
    // drop comes from a full buffer.
    assign ok_inc  = (wr_commit_nxt != wr_commit);
    assign err_inc = drop_nxt && (state != ST_DROP) && !full && s_axis_tuser;
    assign ovf_inc = drop_nxt && !err_inc;

    // Saturating frame statistics.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_ok_cnt  <= 32'd0;
            stat_err_cnt <= 32'd0;
            stat_ovf_cnt <= 32'd0;
        end else begin
            if (ok_inc && (stat_ok_cnt != 32'hFFFF_FFFF)) begin
                stat_ok_cnt <= stat_ok_cnt + 32'd1;
            end
            if (err_inc && (stat_err_cnt != 32'hFFFF_FFFF)) begin
                stat_err_cnt <= stat_err_cnt + 32'd1;
            end
            if (ovf_inc && (stat_ovf_cnt != 32'hFFFF_FFFF)) begin
                stat_ovf_cnt <= stat_ovf_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_frame_fifo
//
// Bench for eth_rx_frame_fifo with ADDR_WIDTH = 4, so the buffer holds 16
// words. The reference model works at the frame level:
//   - A finished frame is queued for output only if it fits in the space
//     that was free when its first word arrived, and its tuser bit is 0.
//   - Every other frame counts as one expected drop.
// A monitor compares every presented output word with the head of the
// expected queue, and pops the queue when the word is accepted.
// ---------------------------------------------------------------------------
module tb_eth_rx_frame_fifo;

    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tready = 1'b0;
    logic          rx_drop;
`ifdef ETH_RX_FIFO_STATS_EN
    logic [31:0]   stat_ok_cnt;
    logic [31:0]   stat_err_cnt;
    logic [31:0]   stat_ovf_cnt;
`endif

    word_t exp_q[$];
    word_t cur_q[$];
    int    cur_space = 0;
    int    checks = 0;
    int    errors = 0;
    int    words_out = 0;
    int    tlasts_out = 0;
    int    drops_seen = 0;
    int    exp_drops = 0;
    int    exp_ok = 0;
    int    exp_err = 0;
    int    exp_ovf = 0;
    int    ready_mode = 0;
    logic  ready_hold = 1'b0;
    logic  prev_stall = 1'b0;

    eth_rx_frame_fifo #(
        .AXIS_DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .rx_drop(rx_drop)
`ifdef ETH_RX_FIFO_STATS_EN
        ,
        .stat_ok_cnt(stat_ok_cnt),
        .stat_err_cnt(stat_err_cnt),
        .stat_ovf_cnt(stat_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stop the run if it stalls.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame-level reference model. It is called once per word sent.
    task automatic modelWord(input word_t w, input logic user);
        if (cur_q.size() == 0) cur_space = DEPTH - exp_q.size();
        cur_q.push_back(w);
        if (w.last) begin
            if (cur_q.size() > cur_space) begin
                exp_drops++;
                exp_ovf++;
            end else if (user) begin
                exp_drops++;
                exp_err++;
            end else begin
                foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                exp_ok++;
            end
            cur_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input word_t w, input logic user);
        s_axis_tdata  = w.data;
        s_axis_tkeep  = w.keep;
        s_axis_tlast  = w.last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        modelWord(w, user);
    endtask

    task automatic sendFrame(input int len, input logic user, input logic [KW-1:0] last_keep,
                             input logic gaps);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = {$urandom, $urandom};
            w.last = (i == len - 1);
            w.keep = w.last ? last_keep : {KW{1'b1}};
            applyStimulus(w, w.last ? user : 1'b0);
            if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
        end
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0) && (n < 400)) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput({tag, "_drain"}, exp_q.size(), 0);
        idle(3);
    endtask

    // Drive tready one time unit after each rising edge:
    //   mode 0  hold ready_hold
    //   mode 1  toggle every clock
    //   mode 2  random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = ready_hold;
                1:       m_axis_tready = !m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) checkOutput("stall_hold_valid", m_axis_tvalid, 1'b1);
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_word", m_axis_tvalid, 1'b0);
                end else begin
                    checkOutput("out_word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q[0]);
                    checkOutput("out_tuser", m_axis_tuser, 1'b0);
                    if (m_axis_tready) begin
                        if (exp_q[0].last) tlasts_out++;
                        void'(exp_q.pop_front());
                        words_out++;
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            if (rx_drop) drops_seen++;
        end
    end

    initial begin
        int w0;
        int t0;
        int n;
        word_t w;

        // Reset values
        idle(3);
        checkOutput("rst_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("rst_tdata", m_axis_tdata, 64'h0);
        checkOutput("rst_tkeep", m_axis_tkeep, 8'h0);
        checkOutput("rst_tlast", m_axis_tlast, 1'b0);
        checkOutput("rst_tuser", m_axis_tuser, 1'b0);
        checkOutput("rst_rx_drop", rx_drop, 1'b0);
        rstn = 1'b1;
        idle(2);

        // Test 1: 8-word good frame; check latency from commit to first valid
        ready_hold = 1'b1;
        idle(2);
        w0 = words_out;
        t0 = tlasts_out;
        sendFrame(8, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        checkOutput("t1_lat_e0", m_axis_tvalid, 1'b0);
        @(negedge clk);
        checkOutput("t1_lat_e1", m_axis_tvalid, 1'b0);
        @(negedge clk);
        checkOutput("t1_lat_e2", m_axis_tvalid, 1'b1);
        waitDrain("t1");
        checkOutput("t1_words", words_out - w0, 8);
        checkOutput("t1_tlasts", tlasts_out - t0, 1);
        checkOutput("t1_drops", drops_seen, exp_drops);

        // Test 2: frame with a bad tuser, then a good 4-word frame
        w0 = words_out;
        sendFrame(6, 1'b1, 8'hFF, 1'b0);
        sendFrame(4, 1'b0, 8'h0F, 1'b0);
        waitDrain("t2");
        checkOutput("t2_words", words_out - w0, 4);
        checkOutput("t2_drops", drops_seen, exp_drops);
`ifdef ETH_RX_FIFO_STATS_EN
        checkOutput("t2_stat_err", stat_err_cnt, exp_err);
`endif

        // Test 3: 20-word frame overflows; the next 3-word frame passes
        w0 = words_out;
        for (int i = 0; i < 20; i++) begin
            w.data = {$urandom, $urandom};
            w.last = (i == 19);
            w.keep = 8'hFF;
            applyStimulus(w, 1'b0);
            if (i == 18) checkOutput("t3_no_early_drop", rx_drop, 1'b0);
            if (i == 19) checkOutput("t3_drop_pulse", rx_drop, 1'b1);
        end
        idle(1);
        checkOutput("t3_drop_width", rx_drop, 1'b0);
        sendFrame(3, 1'b0, 8'h01, 1'b0);
        waitDrain("t3");
        checkOutput("t3_words", words_out - w0, 3);
        checkOutput("t3_drops", drops_seen, exp_drops);
`ifdef ETH_RX_FIFO_STATS_EN
        checkOutput("t3_stat_ovf", stat_ovf_cnt, exp_ovf);
`endif

        // Test 4: three back-to-back 5-word frames, tready toggling
        w0 = words_out;
        t0 = tlasts_out;
        ready_mode = 1;
        sendFrame(5, 1'b0, 8'hFF, 1'b0);
        sendFrame(5, 1'b0, 8'h7F, 1'b0);
        sendFrame(5, 1'b0, 8'h03, 1'b0);
        waitDrain("t4");
        ready_mode = 0;
        ready_hold = 1'b1;
        checkOutput("t4_words", words_out - w0, 15);
        checkOutput("t4_tlasts", tlasts_out - t0, 3);

        // Test 5: single-word frame with a partial tkeep
        w0 = words_out;
        w.data = {$urandom, $urandom};
        w.keep = 8'h3F;
        w.last = 1'b1;
        applyStimulus(w, 1'b0);
        waitDrain("t5");
        checkOutput("t5_words", words_out - w0, 1);

        // Test 6: reset during word 3 of an 8-word frame, with a frame queued
        ready_hold = 1'b0;
        idle(2);
        sendFrame(4, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            w.data = {$urandom, $urandom};
            w.keep = 8'hFF;
            w.last = 1'b0;
            applyStimulus(w, 1'b0);
        end
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        rstn = 1'b0;
        exp_q.delete();
        cur_q.delete();
        exp_ok = 0;
        exp_err = 0;
        exp_ovf = 0;
        @(negedge clk);
        checkOutput("t6_rst_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("t6_rst_tdata", m_axis_tdata, 64'h0);
        checkOutput("t6_rst_tkeep", m_axis_tkeep, 8'h0);
        checkOutput("t6_rst_tlast", m_axis_tlast, 1'b0);
        checkOutput("t6_rst_rx_drop", rx_drop, 1'b0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        rstn = 1'b1;
        w0 = words_out;
        t0 = tlasts_out;
        for (int i = 3; i < 8; i++) begin
            w.data = {$urandom, $urandom};
            w.keep = 8'hFF;
            w.last = (i == 7);
            applyStimulus(w, 1'b0);
        end
        ready_hold = 1'b1;
        waitDrain("t6");
        checkOutput("t6_words", words_out - w0, 5);
        checkOutput("t6_tlasts", tlasts_out - t0, 1);

        // Randomized frames with random tready, tuser and gaps
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int len;
            logic user;
            len  = $urandom_range(1, 6);
            user = ($urandom_range(0, 4) == 0);
            n = 0;
            while (((exp_q.size() + len) > DEPTH) && (n < 300)) begin
                @(posedge clk);
                #1;
                n++;
            end
            checkOutput("rand_space", (exp_q.size() + len) <= DEPTH, 1'b1);
            sendFrame(len, user, 8'($urandom_range(1, 255)), 1'b1);
        end
        ready_mode = 0;
        ready_hold = 1'b1;
        waitDrain("rand");
        checkOutput("rand_drops", drops_seen, exp_drops);
`ifdef ETH_RX_FIFO_STATS_EN
        checkOutput("end_stat_ok", stat_ok_cnt, exp_ok);
        checkOutput("end_stat_err", stat_err_cnt, exp_err);
        checkOutput("end_stat_ovf", stat_ovf_cnt, exp_ovf);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
